// File: rtl/vdp_row_fetch_if.sv
// VDP read port between the row prefetcher (master) and the external memory controller (slave).
interface vdp_row_fetch_if #(
    parameter int VRAM_AW = 14
);
    logic [VRAM_AW-1:0] vdp_addr;
    logic               vdp_read_rq;
    logic               vdp_pipeline_reads;
    logic               vdp_read_ack;
    logic [7:0]         vdp_data_out;

    modport master (
        output vdp_addr, vdp_read_rq, vdp_pipeline_reads,
        input  vdp_read_ack, vdp_data_out
    );

    modport slave (
        input  vdp_addr, vdp_read_rq, vdp_pipeline_reads,
        output vdp_read_ack, vdp_data_out
    );
endinterface

// File: rtl/vdp_row_fetch.sv
// Row prefetcher: one acknowledged read followed by pipelined reads fill a local byte buffer
// that the VDP renderer reads by index with one cycle of latency.
module vdp_row_fetch #(
    parameter int DEPTH_LOG2 = 5,
    parameter int VRAM_AW    = 14
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [VRAM_AW-1:0]    start_addr,
    input  logic [DEPTH_LOG2:0]   length,
    output logic                  busy,
    output logic                  done,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic [7:0]            rd_data,
    vdp_row_fetch_if.master       vdp
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] idx_t;
    typedef enum logic [1:0] {IDLE, WAIT_ACK, STREAM, DRAIN} state_t;
    typedef struct packed {
        logic valid;
        idx_t idx;
    } tag_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rq_q, rq_d;
    logic               pipe_q, pipe_d;
    logic [VRAM_AW-1:0] addr_q, addr_d;
    logic [VRAM_AW-1:0] base_q, base_d;
    idx_t               idx_q, idx_d;
    idx_t               last_q, last_d;
    tag_t               tag1_q, tag1_d;
    tag_t               tag2_q;

    logic [7:0]         row_buf [DEPTH];
    logic               wr_en;
    idx_t               wr_idx;

    idx_t               idx_inc;
    idx_t               len_last;

    assign idx_inc  = idx_q + idx_t'(1);
    // Index of the last byte to fetch; lengths above the buffer depth clamp to a full row.
    assign len_last = length[DEPTH_LOG2] ? '1 : (length[DEPTH_LOG2-1:0] - idx_t'(1));

    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rq_d    = 1'b0;
        pipe_d  = pipe_q;
        addr_d  = addr_q;
        base_d  = base_q;
        idx_d   = idx_q;
        last_d  = last_q;
        tag1_d  = '0;
        wr_en   = 1'b0;
        wr_idx  = tag2_q.idx;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        base_d  = start_addr;
                        last_d  = len_last;
                        idx_d   = '0;
                        addr_d  = start_addr;
                        busy_d  = 1'b1;
                        rq_d    = 1'b1;
                        pipe_d  = (len_last != '0);
                        state_d = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                if (vdp.vdp_read_ack) begin
                    wr_en  = 1'b1;
                    wr_idx = '0;
                    if (last_q == '0) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_inc;
                        addr_d  = base_q + VRAM_AW'(idx_inc);
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                // The tag names the address on the bus this cycle; its byte lands two cycles later.
                tag1_d = '{valid: 1'b1, idx: idx_q};
                if (idx_q == last_q) begin
                    pipe_d  = 1'b0;
                    state_d = DRAIN;
                end else begin
                    idx_d  = idx_inc;
                    addr_d = base_q + VRAM_AW'(idx_inc);
                end
            end
            DRAIN: begin
                if (tag2_q.valid && tag2_q.idx == last_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Beats with no valid tag (duplicates of the first address) are dropped here.
        if (tag2_q.valid) begin
            wr_en  = 1'b1;
            wr_idx = tag2_q.idx;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rq_q    <= 1'b0;
            pipe_q  <= 1'b0;
            addr_q  <= '0;
            base_q  <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            tag1_q  <= '0;
            tag2_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rq_q    <= rq_d;
            pipe_q  <= pipe_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            tag1_q  <= tag1_d;
            tag2_q  <= tag1_q;
        end
    end

    // NOTE: the row buffer is deliberately left out of reset; its contents persist between fetches.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            row_buf[wr_idx] <= vdp.vdp_data_out;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= row_buf[rd_idx];
        end
    end

    assign busy                   = busy_q;
    assign done                   = done_q;
    assign vdp.vdp_addr           = addr_q;
    assign vdp.vdp_read_rq        = rq_q;
    assign vdp.vdp_pipeline_reads = pipe_q;
endmodule

// File: tb/tb_vdp_row_fetch.sv
// Directed bench for vdp_row_fetch: a cycle-level memory-controller model plus a fetch-level
// row-buffer model that is checked against rd_data on every idle cycle.
module tb_vdp_row_fetch;
    localparam int DEPTH_LOG2 = 5;
    localparam int VRAM_AW    = 14;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  start;
    logic [VRAM_AW-1:0]    start_addr;
    logic [DEPTH_LOG2:0]   length;
    logic                  busy;
    logic                  done;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [7:0]            rd_data;

    vdp_row_fetch_if #(.VRAM_AW(VRAM_AW)) vdp ();

    vdp_row_fetch #(.DEPTH_LOG2(DEPTH_LOG2), .VRAM_AW(VRAM_AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .vdp        (vdp)
    );

    always #5 clock = ~clock;

    logic [7:0] vram [1 << VRAM_AW];

    int n_cmp, n_fail;
    int cyc, rq_count, ack_count, done_count, pipe_high_count, busy_count, hold_viol;
    int ack_cyc, done_cyc, start_cyc, ack_delay, wait_left;
    bit pend, acked, prev_pipe, p1_ok, p2_ok;
    logic [VRAM_AW-1:0] rq_addr, drop_addr, prev_addr, p1_addr, p2_addr;
    logic [VRAM_AW-1:0] addr_seq [$];

    // Row-buffer model: byte i of a completed fetch is vram[base + i].
    logic [7:0]            exp_buf [DEPTH];
    bit                    known   [DEPTH];
    logic [VRAM_AW-1:0]    fetch_base;
    int                    fetch_n;
    bit                    prev_busy, prev_reset;
    logic [DEPTH_LOG2-1:0] prev_idx;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic fetch(input logic [VRAM_AW-1:0] base, input int len);
        start_addr = base;
        length     = (DEPTH_LOG2 + 1)'(len);
        start      = 1'b1;
        fetch_base = base;
        fetch_n    = (len > DEPTH) ? DEPTH : len;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int dc0, input int budget);
        int n = 0;
        while (done_count == dc0 && n < budget) begin
            tick();
            n++;
        end
        check("done_within_budget", 32'(done_count != dc0), 1);
    endtask

    task automatic sweep(input int n);
        for (int i = 0; i < n; i++) begin
            rd_idx = DEPTH_LOG2'(i);
            tick();
        end
        tick();
    endtask

    task automatic read_at(input int idx, output logic [7:0] d);
        rd_idx = DEPTH_LOG2'(idx);
        tick();
        d = rd_data;
    endtask

    // Memory controller model, activity monitor and rd_data comparison, all on the falling edge.
    initial begin
        logic       ack_now, cur_ok;
        logic [7:0] beat;
        vdp.vdp_read_ack = 1'b0;
        vdp.vdp_data_out = 8'hEE;
        forever begin
            @(negedge clock);
            cyc++;
            ack_now = 1'b0;
            beat    = 8'hEE;
            if (p2_ok) beat = vram[p2_addr];
            if (reset) begin
                pend = 1'b0;
            end else if (vdp.vdp_read_rq) begin
                rq_count++;
                pend      = 1'b1;
                wait_left = ack_delay;
                rq_addr   = vdp.vdp_addr;
            end else if (pend) begin
                wait_left--;
                if (wait_left <= 0) begin
                    ack_now = 1'b1;
                    pend    = 1'b0;
                    beat    = vram[vdp.vdp_addr];
                    ack_count++;
                    ack_cyc = cyc;
                    addr_seq.push_back(vdp.vdp_addr);
                end
            end
            if ((pend || ack_now) && vdp.vdp_addr != rq_addr) hold_viol++;
            cur_ok = vdp.vdp_pipeline_reads && acked;
            if (cur_ok) addr_seq.push_back(vdp.vdp_addr);
            if (ack_now) acked = 1'b1;
            if (!vdp.vdp_pipeline_reads) acked = 1'b0;
            p2_ok   = p1_ok;
            p2_addr = p1_addr;
            p1_ok   = cur_ok;
            p1_addr = vdp.vdp_addr;
            if (prev_pipe && !vdp.vdp_pipeline_reads) drop_addr = prev_addr;
            prev_pipe = vdp.vdp_pipeline_reads;
            prev_addr = vdp.vdp_addr;
            if (vdp.vdp_pipeline_reads) pipe_high_count++;
            if (busy) busy_count++;
            if (start && !busy && !reset) start_cyc = cyc;
            vdp.vdp_read_ack = ack_now;
            vdp.vdp_data_out = beat;

            if (!reset && !prev_reset && !prev_busy && known[prev_idx])
                check("rd_data_vs_model", 32'(rd_data), 32'(exp_buf[prev_idx]));
            if (!reset && done) begin
                done_count++;
                done_cyc = cyc;
                check("done_busy_exclusive", 32'(busy), 0);
                for (int i = 0; i < fetch_n; i++) begin
                    exp_buf[i] = vram[VRAM_AW'(int'(fetch_base) + i)];
                    known[i]   = 1'b1;
                end
            end
            prev_busy  = busy;
            prev_idx   = rd_idx;
            prev_reset = reset;
        end
    end

    initial begin
        logic [7:0]         d;
        logic [VRAM_AW-1:0] exp_seq [4];
        int                 dc0, ac0, n;

        for (int a = 0; a < (1 << VRAM_AW); a++) vram[a] = 8'(a) ^ 8'h5A;
        vram[14'h1234] = 8'hA5;
        reset = 1'b0; start = 1'b0; start_addr = '0; length = '0; rd_idx = '0; ack_delay = 1;
        #1 reset = 1'b1;
        #2;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_rq", 32'(vdp.vdp_read_rq), 0);
        check("reset_pipe", 32'(vdp.vdp_pipeline_reads), 0);
        check("reset_addr", 32'(vdp.vdp_addr), 0);
        check("reset_rd_data", 32'(rd_data), 0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Single byte, ack three cycles after the request.
        ack_delay = 3; rq_count = 0; pipe_high_count = 0; dc0 = done_count;
        fetch(14'h1234, 1);
        wait_done(dc0, 50);
        check("t1_rq_pulses", rq_count, 1);
        check("t1_pipe_never_high", pipe_high_count, 0);
        check("t1_done_after_ack", done_cyc - ack_cyc, 1);
        read_at(0, d);
        check("t1_buf0", 32'(d), 32'hA5);

        // Full row, no stall.
        ack_delay = 1; rq_count = 0; addr_seq.delete(); dc0 = done_count;
        fetch(14'h0800, 32);
        wait_done(dc0, 200);
        check("t2_rq_pulses", rq_count, 1);
        check("t2_done_latency", done_cyc - ack_cyc, 34);
        check("t2_pipe_drop_addr", 32'(drop_addr), 32'h081F);
        check("t2_addr_count", addr_seq.size(), 32);
        sweep(32);
        read_at(0, d);
        check("t2_buf0", 32'(d), 32'h5A);
        read_at(31, d);
        check("t2_buf31", 32'(d), 32'h45);

        // Length clamped from 40, with a start pulse during busy that must be ignored.
        ack_delay = 4; rq_count = 0; dc0 = done_count;
        fetch(14'h2143, 40);
        tick(); tick(); tick();
        start_addr = 14'h0000; length = 6'd3; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(dc0, 200);
        repeat (5) tick();
        check("t5_rq_pulses", rq_count, 1);
        check("t5_single_done", done_count - dc0, 1);
        check("t5_done_latency", done_cyc - ack_cyc, 34);
        sweep(32);
        read_at(0, d);
        check("t5_buf0", 32'(d), 32'h19);
        read_at(31, d);
        check("t5_buf31", 32'(d), 32'h38);

        // Full row again with the controller stalling before the ack.
        ack_delay = 8; rq_count = 0; hold_viol = 0; dc0 = done_count;
        fetch(14'h0800, 32);
        wait_done(dc0, 200);
        check("t3_addr_held", hold_viol, 0);
        check("t3_rq_pulses", rq_count, 1);
        check("t3_done_latency", done_cyc - ack_cyc, 34);
        sweep(32);
        read_at(5, d);
        check("t3_buf5", 32'(d), 32'h5F);

        // Address wrap at the top of VRAM.
        ack_delay = 2; addr_seq.delete(); dc0 = done_count;
        exp_seq = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
        fetch(14'h3FFE, 4);
        wait_done(dc0, 100);
        check("t4_addr_count", addr_seq.size(), 4);
        for (int i = 0; i < 4 && i < addr_seq.size(); i++)
            check("t4_addr_order", 32'(addr_seq[i]), 32'(exp_seq[i]));
        check("t4_done_latency", done_cyc - ack_cyc, 6);
        sweep(4);
        read_at(1, d);
        check("t4_buf1", 32'(d), 32'hA5);
        read_at(2, d);
        check("t4_buf2", 32'(d), 32'h5A);

        // Zero length: done next cycle, no request, never busy.
        rq_count = 0; busy_count = 0; dc0 = done_count;
        fetch(14'h0123, 0);
        wait_done(dc0, 20);
        check("t5_len0_done_next", done_cyc - start_cyc, 1);
        check("t5_len0_no_rq", rq_count, 0);
        check("t5_len0_never_busy", busy_count, 0);

        // Reset in the 10th streaming cycle, then a short fetch.
        ack_delay = 1; ac0 = ack_count; n = 0;
        fetch(14'h0400, 32);
        while (ack_count == ac0 && n < 50) begin
            tick();
            n++;
        end
        check("t6_ack_within_budget", 32'(ack_count != ac0), 1);
        repeat (9) tick();
        check("t6_streaming_before_reset", 32'(vdp.vdp_pipeline_reads), 1);
        reset = 1'b1;
        #1;
        check("t6_busy_reset", 32'(busy), 0);
        check("t6_rq_reset", 32'(vdp.vdp_read_rq), 0);
        check("t6_pipe_reset", 32'(vdp.vdp_pipeline_reads), 0);
        check("t6_rd_data_reset", 32'(rd_data), 0);
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        dc0 = done_count;
        fetch(14'h0155, 2);
        wait_done(dc0, 50);
        check("t6_done_latency", done_cyc - ack_cyc, 4);
        sweep(2);
        read_at(0, d);
        check("t6_buf0", 32'(d), 32'h0F);
        read_at(1, d);
        check("t6_buf1", 32'(d), 32'h0C);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
